// File: rtl/oclib_csr_array_sticky_if.sv
// CSR request/ready bus between a CSR decoder (master) and a register bank (slave).
interface oclib_csr_array_sticky_if #(
  parameter int DataW = 32,
  parameter int AddrW = 16
);
  logic               csrSelect;
  logic               csrRead;
  logic               csrWrite;
  logic [AddrW-1:0]   csrAddress;
  logic [DataW-1:0]   csrWdata;
  logic [DataW/8-1:0] csrWstrb;
  logic               csrReady;
  logic [DataW-1:0]   csrRdata;
  logic               csrError;

  modport master (
    output csrSelect, csrRead, csrWrite, csrAddress, csrWdata, csrWstrb,
    input  csrReady, csrRdata, csrError
  );

  modport slave (
    input  csrSelect, csrRead, csrWrite, csrAddress, csrWdata, csrWstrb,
    output csrReady, csrRdata, csrError
  );
endinterface

// File: rtl/oclib_csr_array_sticky.sv
// Parametrised CSR bank: RW/RO bits, W1C and clear-on-read sticky events, byte strobes, access pulses.
// Define OCLIB_CSR_ARRAY_STICKY_IRQ_EN to build the registered, CsrIrqBits-masked irq output.
module oclib_csr_array_sticky #(
  parameter int DataW        = 32,
  parameter int NumCsr       = 8,
  parameter int AddrW        = 16,
  parameter int CsrAlignment = 4,
  parameter logic [0:NumCsr-1][DataW-1:0] CsrInitBits = '0,
  parameter logic [0:NumCsr-1][DataW-1:0] CsrRwBits   = '0,
  parameter logic [0:NumCsr-1][DataW-1:0] CsrRoBits   = '0,
  parameter logic [0:NumCsr-1][DataW-1:0] CsrW1cBits  = '0,
  parameter logic [0:NumCsr-1][DataW-1:0] CsrCorBits  = '0,
  parameter logic [0:NumCsr-1][DataW-1:0] CsrIrqBits  = '0
) (
  input  logic                     clock,
  input  logic                     resetN,
  oclib_csr_array_sticky_if.slave  csr,
  output logic [NumCsr*DataW-1:0]  csrOut,
  input  logic [NumCsr*DataW-1:0]  csrIn,
  output logic [NumCsr-1:0]        csrWritePulse,
  output logic [NumCsr-1:0]        csrReadPulse,
  output logic                     irq
);
  localparam int StrbW     = DataW / 8;
  localparam int AlignLog2 = $clog2(CsrAlignment);
  localparam int IdxW      = (NumCsr > 1) ? $clog2(NumCsr) : 1;

  logic [DataW-1:0]  rwReg      [NumCsr];
  logic [DataW-1:0]  sticky     [NumCsr];
  logic [DataW-1:0]  rwNext     [NumCsr];
  logic [DataW-1:0]  stickyNext [NumCsr];
  logic [DataW-1:0]  clrMask    [NumCsr];
  logic [DataW-1:0]  inWord     [NumCsr];
  logic [NumCsr-1:0] hitVec;

  logic [AddrW-1:0]  idxFull;
  logic [IdxW-1:0]   idx;
  logic              inRange;
  logic              accept;
  logic              isErr;
  logic              doRead;
  logic              doWrite;
  logic [DataW-1:0]  wmask;
  logic [DataW-1:0]  readVal;

  logic              readyQ;
  logic              errorQ;
  logic [DataW-1:0]  rdataQ;
  logic [NumCsr-1:0] wrPulseQ;
  logic [NumCsr-1:0] rdPulseQ;

  // Address bits below the CSR stride are dropped here.
  assign idxFull = csr.csrAddress >> AlignLog2;
  assign idx     = idxFull[IdxW-1:0];
  assign inRange = (idxFull < AddrW'(NumCsr));

  // The readyQ term keeps a held request from being taken twice.
  assign accept  = csr.csrSelect & (csr.csrRead | csr.csrWrite) & ~readyQ;
  assign isErr   = ~inRange | (csr.csrRead & csr.csrWrite);
  assign doRead  = accept & ~isErr & csr.csrRead;
  assign doWrite = accept & ~isErr & csr.csrWrite;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < StrbW; b++) begin
      wmask[b*8 +: 8] = {8{csr.csrWstrb[b]}};
    end
  end

  for (genvar g = 0; g < NumCsr; g++) begin : gCsr
    assign inWord[g]                 = csrIn[g*DataW +: DataW];
    assign csrOut[g*DataW +: DataW]  = rwReg[g] & CsrRwBits[g];
  end

  // Read data uses the sticky value before this cycle's set, so a coincident event is not lost.
  always_comb begin
    readVal = '0;
    if (inRange) begin
      readVal = (rwReg[idx]  & CsrRwBits[idx])
              | (inWord[idx] & CsrRoBits[idx])
              | (sticky[idx] & (CsrW1cBits[idx] | CsrCorBits[idx]));
    end
  end

  // Clear first, then OR in new events: a same-cycle set always wins over a clear.
  always_comb begin
    for (int i = 0; i < NumCsr; i++) begin
      hitVec[i]  = inRange && (idxFull == AddrW'(i));
      rwNext[i]  = rwReg[i];
      clrMask[i] = '0;
      if (doWrite && hitVec[i]) begin
        rwNext[i]  = (rwReg[i] & ~(wmask & CsrRwBits[i]))
                   | (csr.csrWdata & wmask & CsrRwBits[i]);
        clrMask[i] = csr.csrWdata & wmask & CsrW1cBits[i];
      end
      if (doRead && hitVec[i]) begin
        clrMask[i] = CsrCorBits[i];
      end
      stickyNext[i] = (sticky[i] & ~clrMask[i])
                    | (inWord[i] & (CsrW1cBits[i] | CsrCorBits[i]));
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NumCsr; i++) begin
        rwReg[i]  <= CsrInitBits[i] & CsrRwBits[i];
        sticky[i] <= '0;
      end
      readyQ   <= 1'b0;
      errorQ   <= 1'b0;
      rdataQ   <= '0;
      wrPulseQ <= '0;
      rdPulseQ <= '0;
    end else begin
      for (int i = 0; i < NumCsr; i++) begin
        rwReg[i]  <= rwNext[i];
        sticky[i] <= stickyNext[i];
      end
      readyQ   <= accept;
      errorQ   <= accept & isErr;
      rdataQ   <= doRead ? readVal : '0;
      wrPulseQ <= doWrite ? hitVec : '0;
      rdPulseQ <= doRead ? hitVec : '0;
    end
  end

  assign csr.csrReady  = readyQ;
  assign csr.csrError  = errorQ;
  assign csr.csrRdata  = rdataQ;
  assign csrWritePulse = wrPulseQ;
  assign csrReadPulse  = rdPulseQ;

`ifdef OCLIB_CSR_ARRAY_STICKY_IRQ_EN
  logic irqAny;
  logic irqQ;

  always_comb begin
    irqAny = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      irqAny = irqAny | (|(sticky[i] & CsrIrqBits[i]));
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      irqQ <= 1'b0;
    end else begin
      irqQ <= irqAny;
    end
  end

  assign irq = irqQ;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_oclib_csr_array_sticky.sv
// Self-checking bench for oclib_csr_array_sticky: directed literal cases plus randomized traffic against a bit-level model.
module tb_oclib_csr_array_sticky;
  localparam int N = 8;
  localparam int W = 32;

  localparam logic [0:N-1][W-1:0] RW   = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h00FF_0000,
                                           32'h0000_0000, 32'hF0F0_F0F0, 32'h0000_00FF, 32'h0000_0000};
  localparam logic [0:N-1][W-1:0] RO   = '{32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 32'hFF00_0000,
                                           32'h0000_0000, 32'h0F00_0000, 32'h0000_0000, 32'hFFFF_FFFF};
  localparam logic [0:N-1][W-1:0] W1C  = '{32'h0, 32'h0, 32'h0, 32'h0000_00FF, 32'h0000_FF00, 32'h0, 32'h0, 32'h0};
  localparam logic [0:N-1][W-1:0] COR  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_00FF, 32'h0, 32'hFFFF_0000, 32'h0};
  localparam logic [0:N-1][W-1:0] INIT = '{32'h1234_5678, 32'hFFFF_BEEF, 32'h0000_00A5, 32'hFFFF_FFFF,
                                           32'h0, 32'hAAAA_AAAA, 32'h0000_0055, 32'h0};
  localparam logic [0:N-1][W-1:0] IRQ  = '{32'h0, 32'h0, 32'h0, 32'h0000_0001, 32'h0000_0100, 32'h0, 32'h0, 32'h0};
`ifdef OCLIB_CSR_ARRAY_STICKY_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic             clock;
  logic             resetN;
  logic [N*W-1:0]   csrOut;
  logic [N*W-1:0]   inVec;
  logic [N-1:0]     csrWritePulse;
  logic [N-1:0]     csrReadPulse;
  logic             irq;

  oclib_csr_array_sticky_if #(.DataW(W), .AddrW(16)) bus ();

  oclib_csr_array_sticky #(
    .DataW(W), .NumCsr(N), .AddrW(16), .CsrAlignment(4),
    .CsrInitBits(INIT), .CsrRwBits(RW), .CsrRoBits(RO),
    .CsrW1cBits(W1C), .CsrCorBits(COR), .CsrIrqBits(IRQ)
  ) dut (
    .clock(clock), .resetN(resetN), .csr(bus.slave),
    .csrOut(csrOut), .csrIn(inVec),
    .csrWritePulse(csrWritePulse), .csrReadPulse(csrReadPulse), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passCnt = 0;
  int totalCnt = 0;
  logic cmpEn = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: per-bit class rules over plain arrays, advanced once per clock edge.
  logic [W-1:0] mRw     [N];
  logic [W-1:0] mSticky [N];
  logic         eReady, eErr, eIrq;
  logic [W-1:0] eRdata;
  logic [N-1:0] eWp, eRp;

  function automatic logic [W-1:0] modelRead(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int b = 0; b < W; b++) begin
      if (RW[k][b])                    v[b] = mRw[k][b];
      else if (RO[k][b])               v[b] = inVec[k*W + b];
      else if (W1C[k][b] || COR[k][b]) v[b] = mSticky[k][b];
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] modelOut();
    logic [N*W-1:0] o;
    o = '0;
    for (int k = 0; k < N; k++)
      for (int b = 0; b < W; b++)
        if (RW[k][b]) o[k*W + b] = mRw[k][b];
    return o;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      mRw[k]     = INIT[k] & RW[k];
      mSticky[k] = '0;
    end
    eReady = 1'b0; eErr = 1'b0; eRdata = '0; eWp = '0; eRp = '0; eIrq = 1'b0;
  endtask

  task automatic modelStep();
    logic acc, bad, anyIrq;
    int k;
    logic [W-1:0] rdv;
    logic [N-1:0] wp, rp;
    anyIrq = 1'b0;
    for (int c = 0; c < N; c++)
      for (int b = 0; b < W; b++)
        if (IRQ[c][b] && mSticky[c][b]) anyIrq = 1'b1;
    acc = bus.csrSelect && (bus.csrRead || bus.csrWrite) && !eReady;
    k   = int'(bus.csrAddress) / 4;
    bad = (k >= N) || (bus.csrRead && bus.csrWrite);
    rdv = '0; wp = '0; rp = '0;
    if (acc && !bad && bus.csrRead) begin
      rdv = modelRead(k);
      rp[k] = 1'b1;
      for (int b = 0; b < W; b++) if (COR[k][b]) mSticky[k][b] = 1'b0;
    end
    if (acc && !bad && bus.csrWrite) begin
      wp[k] = 1'b1;
      for (int b = 0; b < W; b++) begin
        if (bus.csrWstrb[b/8]) begin
          if (RW[k][b]) mRw[k][b] = bus.csrWdata[b];
          if (W1C[k][b] && bus.csrWdata[b]) mSticky[k][b] = 1'b0;
        end
      end
    end
    for (int c = 0; c < N; c++)
      for (int b = 0; b < W; b++)
        if ((W1C[c][b] || COR[c][b]) && inVec[c*W + b]) mSticky[c][b] = 1'b1;
    eReady = acc; eErr = acc && bad; eRdata = rdv; eWp = wp; eRp = rp;
    eIrq = IRQ_ON && anyIrq;
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge resetN);
      if (!resetN) modelReset();
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmpEn) begin
        check("ready", 256'(bus.csrReady), 256'(eReady));
        check("error", 256'(bus.csrError), 256'(eErr));
        check("rdata", 256'(bus.csrRdata), 256'(eRdata));
        check("wrPulse", 256'(csrWritePulse), 256'(eWp));
        check("rdPulse", 256'(csrReadPulse), 256'(eRp));
        check("irq", 256'(irq), 256'(eIrq));
        check("csrOut", 256'(csrOut), 256'(modelOut()));
      end
    end
  end

  task automatic busTxn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rdata, output logic err,
                        output logic [N-1:0] wp, output logic [N-1:0] rp);
    int n;
    @(negedge clock);
    bus.csrSelect = 1'b1; bus.csrRead = rd; bus.csrWrite = wr;
    bus.csrAddress = addr; bus.csrWdata = wd; bus.csrWstrb = st;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.csrReady && n < 8);
    check("txnLatency", 256'(n), 256'(1));
    rdata = bus.csrRdata; err = bus.csrError; wp = csrWritePulse; rp = csrReadPulse;
    bus.csrSelect = 1'b0; bus.csrRead = 1'b0; bus.csrWrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [N-1:0] wp, rp;

  initial begin
    resetN = 1'b0; inVec = '0;
    bus.csrSelect = 1'b0; bus.csrRead = 1'b0; bus.csrWrite = 1'b0;
    bus.csrAddress = '0; bus.csrWdata = '0; bus.csrWstrb = '0;
    repeat (3) @(negedge clock);
    cmpEn = 1'b1;
    check("rstReady", 256'(bus.csrReady), 256'(0));
    check("rstIrq", 256'(irq), 256'(0));
    resetN = 1'b1;
    @(negedge clock);
    check("rstCsr2", 256'(csrOut[2*W +: W]), 256'(32'hA5));

    busTxn(1, 0, 16'd8, 32'h0, 4'h0, rd, er, wp, rp);
    check("rstRead8", 256'(rd), 256'(32'hA5));
    check("rstReadPulse", 256'(rp), 256'(8'b0000_0100));

    busTxn(0, 1, 16'd8, 32'h0000_A500, 4'b0010, rd, er, wp, rp);
    busTxn(0, 1, 16'd8, 32'h0000_1234, 4'b0001, rd, er, wp, rp);
    check("strbCsr2", 256'(csrOut[2*W +: W]), 256'(32'hA534));
    check("strbWrPulse", 256'(wp), 256'(8'b0000_0100));
    check("strbRdata", 256'(rd), 256'(0));

    // W1C event on CSR3 bit 0, which is also an irq source.
    @(negedge clock); inVec[3*W] = 1'b1;
    @(negedge clock); inVec[3*W] = 1'b0;
    check("irqNotYet", 256'(irq), 256'(0));
    @(negedge clock);
    check("irqSet", 256'(irq), 256'(IRQ_ON));
    busTxn(1, 0, 16'd12, 32'h0, 4'h0, rd, er, wp, rp);
    check("w1cRead1", 256'(rd), 256'(32'h00FF_0001));
    busTxn(1, 0, 16'd14, 32'h0, 4'h0, rd, er, wp, rp);
    check("w1cRead2", 256'(rd), 256'(32'h00FF_0001));
    busTxn(0, 1, 16'd12, 32'h1, 4'b0001, rd, er, wp, rp);
    busTxn(1, 0, 16'd12, 32'h0, 4'h0, rd, er, wp, rp);
    check("w1cCleared", 256'(rd), 256'(32'h00FF_0000));
    check("irqCleared", 256'(irq), 256'(0));

    // COR on CSR4 bit 0 with the event still present during the read.
    @(negedge clock); inVec[4*W] = 1'b1;
    busTxn(1, 0, 16'd16, 32'h0, 4'h0, rd, er, wp, rp);
    check("corSameCycle", 256'(rd), 256'(32'h1));
    inVec[4*W] = 1'b0;
    busTxn(1, 0, 16'd16, 32'h0, 4'h0, rd, er, wp, rp);
    check("corKept", 256'(rd), 256'(32'h1));
    busTxn(1, 0, 16'd16, 32'h0, 4'h0, rd, er, wp, rp);
    check("corCleared", 256'(rd), 256'(32'h0));

    busTxn(1, 0, 16'(4*N), 32'h0, 4'h0, rd, er, wp, rp);
    check("errRangeFlag", 256'(er), 256'(1));
    check("errRangeData", 256'(rd), 256'(0));
    busTxn(1, 1, 16'd8, 32'hFFFF_FFFF, 4'hF, rd, er, wp, rp);
    check("errBothFlag", 256'(er), 256'(1));
    check("errBothPulse", 256'({wp, rp}), 256'(0));
    check("errBothCsr2", 256'(csrOut[2*W +: W]), 256'(32'hA534));

    // Reset in the ready cycle of a read: dropped response, registers back to reset values.
    @(negedge clock);
    bus.csrSelect = 1'b1; bus.csrRead = 1'b1; bus.csrAddress = 16'd8;
    @(posedge clock); #1;
    resetN = 1'b0;
    #1;
    check("midRstReady", 256'(bus.csrReady), 256'(0));
    check("midRstCsr2", 256'(csrOut[2*W +: W]), 256'(32'hA5));
    bus.csrSelect = 1'b0; bus.csrRead = 1'b0;
    @(negedge clock); resetN = 1'b1;
    repeat (2) @(negedge clock);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      if (cyc == 1000) begin
        #2 resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
      end
      if ($urandom_range(3, 0) != 0) begin
        int op;
        op = int'($urandom_range(7, 0));
        bus.csrSelect  = ($urandom_range(7, 0) != 0);
        bus.csrRead    = (op <= 3) || (op == 7);
        bus.csrWrite   = (op >= 4);
        bus.csrAddress = 16'($urandom_range(9, 0) * 4 + $urandom_range(3, 0));
        if ($urandom_range(15, 0) == 0) bus.csrAddress = 16'($urandom);
        bus.csrWdata   = $urandom;
        bus.csrWstrb   = 4'($urandom);
      end
      for (int k = 0; k < N; k++) inVec[k*W +: W] = $urandom & $urandom & $urandom;
    end

    @(negedge clock);
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
